// File: rtl/lantern_ctrl.sv
// Front-panel button conditioning for the LED chaser: synchronize, debounce and
// edge-detect four keys, then drive clear, pause, speed and a speed digit.
module lantern_ctrl #(
   parameter int DB_CYCLES = 1000000,
   parameter int CLR_HOLD  = 10000000,
   parameter int SPEED_MAX = 9
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        key_run_n,
   input  logic        key_up_n,
   input  logic        key_down_n,
   input  logic        key_clr_n,
   output logic        clr_out,
   output logic        stop_out,
   output logic [15:0] speed_out,
   output logic [6:0]  seg_n
);

   localparam int DBW = $clog2(DB_CYCLES);
   localparam int HW  = (CLR_HOLD > 1) ? $clog2(CLR_HOLD) : 1;
   localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
   localparam logic [HW-1:0]  HOLD_LOAD = HW'(CLR_HOLD - 1);
   localparam logic [3:0]     SPD_MAX   = 4'(SPEED_MAX);

   localparam int K_RUN  = 0;
   localparam int K_UP   = 1;
   localparam int K_DOWN = 2;
   localparam int K_CLR  = 3;

   function automatic logic [6:0] seg_decode(input logic [3:0] v);
      case (v)
         4'd0:    seg_decode = 7'b1000000;
         4'd1:    seg_decode = 7'b1111001;
         4'd2:    seg_decode = 7'b0100100;
         4'd3:    seg_decode = 7'b0110000;
         4'd4:    seg_decode = 7'b0011001;
         4'd5:    seg_decode = 7'b0010010;
         4'd6:    seg_decode = 7'b0000010;
         4'd7:    seg_decode = 7'b1111000;
         4'd8:    seg_decode = 7'b0000000;
         4'd9:    seg_decode = 7'b0010000;
         default: seg_decode = 7'b0111111;
      endcase
   endfunction

   logic [3:0]     w_keys_n;
   logic [3:0]     r_sync1;
   logic [3:0]     r_sync2;
   logic [3:0]     r_db_lvl;
   logic [3:0]     r_db_dly;
   logic [3:0]     r_press;
   logic [DBW-1:0] r_db_cnt [4];
   logic [HW-1:0]  r_hold;
   logic [3:0]     r_speed;
   logic [3:0]     w_speed_nxt;
   logic [6:0]     r_seg;
   logic           r_clr;
   logic           r_stop;

   assign w_keys_n = {key_clr_n, key_down_n, key_up_n, key_run_n};

   // Synchronizers, per-key debounce counters and registered press pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1  <= 4'b1111;
         r_sync2  <= 4'b1111;
         r_db_lvl <= 4'b1111;
         r_db_dly <= 4'b1111;
         r_press  <= 4'b0000;
         for (int i = 0; i < 4; i++) begin
            r_db_cnt[i] <= {DBW{1'b0}};
         end
      end else begin
         r_sync1  <= w_keys_n;
         r_sync2  <= r_sync1;
         r_db_dly <= r_db_lvl;
         r_press  <= r_db_dly & ~r_db_lvl;
         for (int i = 0; i < 4; i++) begin
            if (r_sync2[i] == r_db_lvl[i]) begin
               r_db_cnt[i] <= {DBW{1'b0}};
            end else if (r_db_cnt[i] == DB_LAST) begin
               r_db_lvl[i] <= r_sync2[i];
               r_db_cnt[i] <= {DBW{1'b0}};
            end else begin
               r_db_cnt[i] <= r_db_cnt[i] + DBW'(1);
            end
         end
      end
   end

   // Saturating speed step; simultaneous up and down cancel
   always_comb begin
      w_speed_nxt = r_speed;
      if (r_press[K_UP] && !r_press[K_DOWN]) begin
         if (r_speed < SPD_MAX) begin
            w_speed_nxt = r_speed + 4'd1;
         end else begin
            w_speed_nxt = r_speed;
         end
      end else if (r_press[K_DOWN] && !r_press[K_UP]) begin
         if (r_speed != 4'd0) begin
            w_speed_nxt = r_speed - 4'd1;
         end else begin
            w_speed_nxt = r_speed;
         end
      end else begin
         w_speed_nxt = r_speed;
      end
   end

   // Output state: speed, digit, retriggerable clear hold, pause toggle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_speed <= 4'd0;
         r_seg   <= 7'b1000000;
         r_clr   <= 1'b0;
         r_hold  <= {HW{1'b0}};
         r_stop  <= 1'b0;
      end else begin
         r_speed <= w_speed_nxt;
         r_seg   <= seg_decode(r_speed);
         if (r_press[K_CLR]) begin
            r_clr  <= 1'b1;
            r_hold <= HOLD_LOAD;
         end else if (r_hold != {HW{1'b0}}) begin
            r_clr  <= 1'b1;
            r_hold <= r_hold - HW'(1);
         end else begin
            r_clr  <= 1'b0;
         end
         if (r_press[K_CLR]) begin
            r_stop <= 1'b0;
         end else if (r_press[K_RUN]) begin
            r_stop <= ~r_stop;
         end else begin
            r_stop <= r_stop;
         end
      end
   end

   assign clr_out   = r_clr;
   assign stop_out  = r_stop;
   assign speed_out = {12'd0, r_speed};
   assign seg_n     = r_seg;

endmodule

// File: tb/tb_lantern_ctrl.sv
// Directed bench for lantern_ctrl with short debounce and clear-hold times.
module tb_lantern_ctrl;

   logic        clk;
   logic        rst;
   logic [3:0]  keys_n;
   logic        clr_out;
   logic        stop_out;
   logic [15:0] speed_out;
   logic [6:0]  seg_n;

   int n_pass;
   int n_total;

   lantern_ctrl #(
      .DB_CYCLES(4),
      .CLR_HOLD (8),
      .SPEED_MAX(9)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .key_run_n (keys_n[0]),
      .key_up_n  (keys_n[1]),
      .key_down_n(keys_n[2]),
      .key_clr_n (keys_n[3]),
      .clr_out   (clr_out),
      .stop_out  (stop_out),
      .speed_out (speed_out),
      .seg_n     (seg_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total = n_total + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Clean press: held long enough to debounce, then released long enough to settle
   task automatic press(input int k);
      keys_n[k] = 1'b0;
      tick(10);
      keys_n[k] = 1'b1;
      tick(10);
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      keys_n  = 4'b1111;
      rst     = 1'b1;

      tick(3);
      check("rst_clr",   {15'd0, clr_out},  16'd0);
      check("rst_stop",  {15'd0, stop_out}, 16'd0);
      check("rst_speed", speed_out,         16'd0);
      check("rst_seg",   {9'd0, seg_n},     {9'd0, 7'b1000000});
      keys_n[1] = 1'b0;
      tick(2);
      keys_n[1] = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(20);
      check("rst_press_dropped", speed_out, 16'd0);

      keys_n[1] = 1'b0; tick(3);
      keys_n[1] = 1'b1; tick(1);
      keys_n[1] = 1'b0; tick(3);
      keys_n[1] = 1'b1; tick(10);
      check("bounce_reject", speed_out, 16'd0);

      keys_n[1] = 1'b0;
      tick(7);
      check("up_lat7", speed_out, 16'd0);
      tick(1);
      check("up_lat8", speed_out, 16'd1);
      tick(1);
      check("up_seg1", {9'd0, seg_n}, {9'd0, 7'b1111001});
      tick(100);
      check("up_hold_once", speed_out, 16'd1);
      keys_n[1] = 1'b1;
      tick(10);

      for (int i = 0; i < 12; i++) press(1);
      check("sat_up_speed", speed_out, 16'd9);
      check("sat_up_seg", {9'd0, seg_n}, {9'd0, 7'b0010000});
      for (int i = 0; i < 11; i++) press(2);
      check("sat_dn_speed", speed_out, 16'd0);
      check("sat_dn_seg", {9'd0, seg_n}, {9'd0, 7'b1000000});

      for (int i = 0; i < 5; i++) press(1);
      check("five_speed", speed_out, 16'd5);
      keys_n[1] = 1'b0;
      keys_n[2] = 1'b0;
      tick(10);
      keys_n[1] = 1'b1;
      keys_n[2] = 1'b1;
      tick(10);
      check("simul_speed", speed_out, 16'd5);
      check("simul_seg", {9'd0, seg_n}, {9'd0, 7'b0010010});

      keys_n[0] = 1'b0;
      tick(10);
      check("run_press1", {15'd0, stop_out}, 16'd1);
      keys_n[0] = 1'b1;
      tick(10);
      check("run_release", {15'd0, stop_out}, 16'd1);
      press(0);
      check("run_press2", {15'd0, stop_out}, 16'd0);
      press(0);
      check("run_press3", {15'd0, stop_out}, 16'd1);

      keys_n[3] = 1'b0;
      tick(7);
      check("clr_before", {15'd0, clr_out}, 16'd0);
      for (int i = 0; i < 8; i++) begin
         tick(1);
         check("clr_hold", {15'd0, clr_out}, 16'd1);
      end
      tick(1);
      check("clr_end", {15'd0, clr_out}, 16'd0);
      check("clr_stop", {15'd0, stop_out}, 16'd0);
      check("clr_speed", speed_out, 16'd5);
      keys_n[3] = 1'b1;
      tick(10);

      // Second press pulse lands while the first hold is still running
      keys_n[3] = 1'b0; tick(4);
      keys_n[3] = 1'b1; tick(4);
      check("retrig_first", {15'd0, clr_out}, 16'd1);
      keys_n[3] = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick(1);
         check("retrig_hold", {15'd0, clr_out}, 16'd1);
      end
      tick(1);
      check("retrig_end", {15'd0, clr_out}, 16'd0);
      keys_n[3] = 1'b1;
      tick(10);

      keys_n[3] = 1'b0;
      tick(10);
      check("mid_hold_high", {15'd0, clr_out}, 16'd1);
      keys_n[3] = 1'b1;
      rst = 1'b1;
      tick(1);
      check("mid_rst_clr",   {15'd0, clr_out}, 16'd0);
      check("mid_rst_speed", speed_out,        16'd0);
      rst = 1'b0;
      tick(2);
      check("mid_rst_seg", {9'd0, seg_n}, {9'd0, 7'b1000000});

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
